// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the fabric configuration loader.
package fpga_cfg_pkg;

  localparam int LUT_MEM_W     = 33;
  localparam int CFG_WORD_W    = 32;
  localparam int DEF_NUM_LUTS  = 24;
  localparam int DEF_NUM_CELLS = 17;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_LUT,
    LOAD_CELL,
    CHECK,
    DONE,
    ERROR
  } cfg_state_e;

  // Index width covering the larger of the two target groups (never below 1 bit).
  function automatic int idx_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/cfg_checksum_acc.sv
// Running mod-2^32 sum of accepted configuration words, compared against the trailing word.
import fpga_cfg_pkg::*;

module cfg_checksum_acc (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_add,
  input  logic [CFG_WORD_W-1:0] i_word,
  output logic                  o_match
);

  logic [CFG_WORD_W-1:0] r_sum;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_add) begin
      r_sum <= r_sum + i_word;
    end
  end

  assign o_match = (r_sum == i_word);

endmodule

// File: rtl/fpga_config_loader.sv
// Streams configuration words into fabric LUT memories and cell registers,
// then validates the load against a trailing checksum word.
import fpga_cfg_pkg::*;

module fpga_config_loader #(
  parameter int NUM_LUTS   = DEF_NUM_LUTS,
  parameter int NUM_CELLS  = DEF_NUM_CELLS,
  parameter int CELL_CFG_W = 32
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_cfg_start,
  input  logic [CFG_WORD_W-1:0]             i_cfg_data,
  input  logic                              i_cfg_valid,
  output logic                              o_cfg_ready,
  output logic [NUM_LUTS*LUT_MEM_W-1:0]     o_lut_mem,
  output logic [NUM_CELLS*CELL_CFG_W-1:0]   o_cell_cfg,
  output logic                              o_cfg_done,
  output logic                              o_cfg_error,
  output logic                              o_fabric_en
);

  localparam int IDX_W = idx_width(NUM_LUTS, NUM_CELLS);

  cfg_state_e       r_state;
  cfg_state_e       w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_ready;
  logic             r_done;
  logic             r_error;

  logic w_accept;
  logic w_clear;
  logic w_add;
  logic w_lut_we;
  logic w_cell_we;
  logic w_last_lut;
  logic w_last_cell;
  logic w_match;

  assign w_accept    = i_cfg_valid && r_ready;
  assign w_last_lut  = (r_idx == IDX_W'(NUM_LUTS - 1));
  assign w_last_cell = (r_idx == IDX_W'(NUM_CELLS - 1));

  cfg_checksum_acc u_checksum (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (w_clear),
    .i_add   (w_add),
    .i_word  (i_cfg_data),
    .o_match (w_match)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_add        = 1'b0;
    w_lut_we     = 1'b0;
    w_cell_we    = 1'b0;
    case (r_state)
      IDLE, DONE, ERROR: begin
        if (i_cfg_start) begin
          w_state_next = LOAD_LUT;
          w_clear      = 1'b1;
        end
      end
      LOAD_LUT: begin
        if (w_accept) begin
          w_lut_we = 1'b1;
          w_add    = 1'b1;
          if (w_last_lut) w_state_next = LOAD_CELL;
        end
      end
      LOAD_CELL: begin
        if (w_accept) begin
          w_cell_we = 1'b1;
          w_add     = 1'b1;
          if (w_last_cell) w_state_next = CHECK;
        end
      end
      CHECK: begin
        if (w_accept) w_state_next = w_match ? DONE : ERROR;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with r_state.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_idx   <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      if (w_clear) begin
        r_idx <= '0;
      end else if (w_lut_we) begin
        r_idx <= w_last_lut ? '0 : r_idx + 1'b1;
      end else if (w_cell_we) begin
        r_idx <= w_last_cell ? '0 : r_idx + 1'b1;
      end
      r_ready <= (w_state_next == LOAD_LUT) || (w_state_next == LOAD_CELL) ||
                 (w_state_next == CHECK);
      r_done  <= (w_state_next == DONE);
      r_error <= (w_state_next == ERROR);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LUTS; gi++) begin : g_lut
      logic [LUT_MEM_W-1:0] r_mem;
      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          r_mem <= '0;
        end else if (w_lut_we && (r_idx == IDX_W'(gi))) begin
          r_mem <= {1'b0, i_cfg_data};
        end
      end
      assign o_lut_mem[gi*LUT_MEM_W +: LUT_MEM_W] = r_mem;
    end

    for (gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
      logic [CELL_CFG_W-1:0] r_cfg;
      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          r_cfg <= '0;
        end else if (w_cell_we && (r_idx == IDX_W'(gi))) begin
          r_cfg <= CELL_CFG_W'(i_cfg_data);
        end
      end
      assign o_cell_cfg[gi*CELL_CFG_W +: CELL_CFG_W] = r_cfg;
    end
  endgenerate

  assign o_cfg_ready = r_ready;
  assign o_cfg_done  = r_done;
  assign o_cfg_error = r_error;
  assign o_fabric_en = r_done;

endmodule

// File: tb/tb_fpga_config_loader.sv
// Randomized scoreboard bench for fpga_config_loader against a word-stream reference model.
module tb_fpga_config_loader;
  import fpga_cfg_pkg::*;

  localparam int NL = 24;
  localparam int NC = 17;
  localparam int CW = 32;
  localparam int NW = NL + NC + 1;

  logic              clk   = 1'b0;
  logic              rst   = 1'b1;
  logic              start = 1'b0;
  logic              valid = 1'b0;
  logic [31:0]       data  = '0;
  logic              ready;
  logic              done;
  logic              error;
  logic              fab;
  logic [NL*33-1:0]  lut_mem;
  logic [NC*CW-1:0]  cell_cfg;

  always #5 clk = ~clk;

  fpga_config_loader #(.NUM_LUTS(NL), .NUM_CELLS(NC), .CELL_CFG_W(CW)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_cfg_start (start),
    .i_cfg_data  (data),
    .i_cfg_valid (valid),
    .o_cfg_ready (ready),
    .o_lut_mem   (lut_mem),
    .o_cell_cfg  (cell_cfg),
    .o_cfg_done  (done),
    .o_cfg_error (error),
    .o_fabric_en (fab)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: what the fabric should hold, derived only from the word order.
  logic [32:0] m_lut [NL];
  logic [31:0] m_cell[NC];
  logic [31:0] m_sum;
  int          m_pos;
  bit          m_done;
  bit          m_err;

  typedef struct {
    int          kind;
    int          idx;
    logic [63:0] val;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] stream[NW];

  task automatic model_clear();
    for (int i = 0; i < NL; i++) m_lut[i] = '0;
    for (int i = 0; i < NC; i++) m_cell[i] = '0;
    m_pos = 0; m_sum = '0; m_done = 0; m_err = 0;
  endtask

  task automatic model_push(input logic [31:0] w);
    exp_t e;
    if (m_pos < NL) begin
      m_lut[m_pos] = {1'b0, w};
      e = '{kind: 0, idx: m_pos, val: 64'({1'b0, w})};
      m_sum += w;
    end else if (m_pos < NL + NC) begin
      m_cell[m_pos - NL] = w;
      e = '{kind: 1, idx: m_pos - NL, val: 64'(w)};
      m_sum += w;
    end else begin
      m_done = (w == m_sum);
      m_err  = !m_done;
      e = '{kind: 2, idx: 0, val: 64'({m_done, m_err})};
    end
    sbq.push_back(e);
    m_pos++;
  endtask

  // Monitor: an accept seen before an edge is checked against the queue after that edge.
  initial begin
    bit   pend;
    exp_t e;
    pend = 0;
    forever begin
      @(negedge clk);
      if (pend && !rst) begin
        if (sbq.size() == 0) begin
          chk("unexpected_accept", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          $display("txn kind=%0d idx=%0d exp=%0h", e.kind, e.idx, e.val);
          case (e.kind)
            0: chk($sformatf("mon_lut%0d", e.idx), 64'(lut_mem[e.idx*33 +: 33]), e.val);
            1: chk($sformatf("mon_cell%0d", e.idx), 64'(cell_cfg[e.idx*CW +: CW]), e.val);
            default: begin
              chk("mon_done_error", 64'({done, error}), e.val);
              chk("mon_fabric_en", 64'(fab), 64'(e.val[1]));
              chk("mon_ready_after_check", 64'(ready), 64'd0);
            end
          endcase
        end
      end
      pend = valid && ready && !rst;
    end
  end

  // All driving happens 1 time unit after a rising edge.
  task automatic send(input logic [31:0] w, input bit with_start, input int max_gap);
    int g;
    int n;
    g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    repeat (g) begin
      valid = 1'b0;
      data  = $urandom;
      @(posedge clk); #1;
    end
    valid = 1'b1;
    data  = w;
    start = with_start;
    n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) begin
      chk("ready_timeout", 64'd0, 64'd1);
      valid = 1'b0;
      start = 1'b0;
      return;
    end
    model_push(w);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic start_load();
    valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_pos = 0; m_sum = '0; m_done = 0; m_err = 0;
    chk("ready_after_start", 64'(ready), 64'd1);
    chk("done_after_start", 64'(done), 64'd0);
    chk("error_after_start", 64'(error), 64'd0);
  endtask

  task automatic run_stream(input int max_gap, input int start_at);
    for (int k = 0; k < NW; k++) send(stream[k], (k == start_at), max_gap);
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < NL; i++)
      chk($sformatf("%s_lut%0d", tag, i), 64'(lut_mem[i*33 +: 33]), 64'(m_lut[i]));
    for (int i = 0; i < NC; i++)
      chk($sformatf("%s_cell%0d", tag, i), 64'(cell_cfg[i*CW +: CW]), 64'(m_cell[i]));
    chk({tag, "_done"}, 64'(done), 64'(m_done));
    chk({tag, "_error"}, 64'(error), 64'(m_err));
    chk({tag, "_fabric_en"}, 64'(fab), 64'(m_done));
    chk({tag, "_ready"}, 64'(ready), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_lut_zero"}, 64'(|lut_mem), 64'd0);
    chk({tag, "_cell_zero"}, 64'(|cell_cfg), 64'd0);
    chk({tag, "_ready"}, 64'(ready), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_fabric_en"}, 64'(fab), 64'd0);
  endtask

  task automatic fill_nominal();
    for (int k = 0; k < 8; k++)  stream[k] = 32'h0000_0000;
    for (int k = 8; k < 16; k++) stream[k] = 32'hFF00_F0F0;
    for (int k = 16; k < 20; k++) stream[k] = 32'hFAFA_A0A0;
    for (int k = 20; k < 24; k++) stream[k] = 32'hA5A5_5A5A;
    stream[NL] = 32'h0000_0000;
    for (int k = NL + 1; k < NL + NC; k++) stream[k] = 32'h0000_0008;
    stream[NW-1] = 32'h7A87_73E8;
  endtask

  function automatic logic [31:0] stream_sum();
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < NW - 1; k++) s += stream[k];
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_ready_low", 64'(ready), 64'd0);
    end

    // Reset mid-stream after 10 accepted words.
    fill_nominal();
    start_load();
    for (int k = 0; k < 10; k++) send(stream[k], 1'b0, 0);
    valid = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check_zero("midreset");
    #2;
    rst = 1'b0;
    model_clear();
    sbq.delete();
    @(posedge clk); #1;
    valid = 1'b1;
    data  = 32'hDEAD_BEEF;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_reset_ready_low", 64'(ready), 64'd0);
    end
    valid = 1'b0;
    chk("post_reset_lut_zero", 64'(|lut_mem), 64'd0);

    // Nominal load, then a held valid in DONE must change nothing.
    start_load();
    run_stream(0, -1);
    compare_all("nominal");
    chk("nominal_done", 64'(done), 64'd1);
    chk("nominal_fabric_en", 64'(fab), 64'd1);
    chk("nominal_lut8", 64'(lut_mem[8*33 +: 33]), 64'h0_FF00_F0F0);
    chk("nominal_cell5", 64'(cell_cfg[5*CW +: CW]), 64'h0000_0008);
    valid = 1'b1;
    repeat (5) begin
      data = $urandom;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    compare_all("done_hold");

    // Start in DONE drops done; then a bad checksum.
    chk("pre_restart_done", 64'(done), 64'd1);
    start_load();
    stream[NW-1] = 32'h7A87_73E9;
    run_stream(0, -1);
    compare_all("badsum");
    chk("badsum_error", 64'(error), 64'd1);
    chk("badsum_done", 64'(done), 64'd0);
    chk("badsum_ready", 64'(ready), 64'd0);

    // Random stalls, with an ignored start pulse during LOAD_CELL.
    fill_nominal();
    start_load();
    run_stream(3, NL + 3);
    compare_all("stall");
    chk("stall_done", 64'(done), 64'd1);

    // Reload: old contents persist until overwritten.
    start_load();
    chk("reload_keeps_lut12", 64'(lut_mem[12*33 +: 33]), 64'h0_FF00_F0F0);
    stream[0]    = 32'h1234_5678;
    stream[NW-1] = stream_sum();
    run_stream(1, -1);
    compare_all("reload");
    chk("reload_lut0", 64'(lut_mem[32:0]), 64'h0_1234_5678);
    chk("reload_done", 64'(done), 64'd1);

    // Random streams with a correct or corrupted checksum.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NW - 1; k++) stream[k] = $urandom;
      stream[NW-1] = stream_sum();
      if ($urandom_range(1, 0) == 1) stream[NW-1] = stream[NW-1] ^ (32'd1 << $urandom_range(31, 0));
      start_load();
      run_stream(2, (r == 1) ? NL + 1 : -1);
      compare_all($sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpga_config_loader.md
# fpga_config_loader

Configuration loader that sits directly upstream of `universal_shift_register` and writes every LUT memory and cell configure register in the fabric. It takes an ordered stream of 32-bit configuration words over a valid/ready handshake and validates them against a trailing checksum word. Once loaded, it holds the fabric configuration static and raises `cfg_done`, which gates the fabric's `control` path.

## Interface
- `NUM_LUTS`, default 24: LUT instances `ins1..insN`; each has a 33-bit `mem`.
- `NUM_CELLS`, default 17: cell instances `inst1..instN`; each has a `configure` register.
- `CELL_CFG_W`, default 32: width of each cell `configure` register.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `cfg_start` input 1: start or restart a load; sampled on the clock.
- `cfg_data` input 32: configuration word.
- `cfg_valid` input 1: `cfg_data` is valid.
- `cfg_ready` output 1: loader accepts a word this cycle.
- `lut_mem` output NUM_LUTS*33: LUT k occupies bits [33k+32:33k].
- `cell_cfg` output NUM_CELLS*CELL_CFG_W: cell k occupies slice k.
- `cfg_done` output 1: configuration loaded and checksum matched.
- `cfg_error` output 1: checksum mismatch.
- `fabric_en` output 1: equals `cfg_done`; the downstream fabric enable.

## Operation
- A word is accepted on a rising edge when `cfg_valid && cfg_ready`.
- Word order:
  - NUM_LUTS LUT words first, for LUT 0 upward.
  - NUM_CELLS cell words next, for cell 0 upward.
  - One checksum word last.
- LUT word w is written as `{1'b0, w}`.
- Cell word w is written as `w[CELL_CFG_W-1:0]`.
- Running checksum is the sum, mod 2^32, of all words accepted before the checksum word.
- States and transitions:
  - IDLE: `cfg_ready`=0. `cfg_start` moves to LOAD_LUT and clears the index, checksum, `cfg_done` and `cfg_error`.
  - LOAD_LUT: `cfg_ready`=1. Each accept writes LUT[idx] and increments idx. The accept at idx=NUM_LUTS-1 moves to LOAD_CELL with idx=0.
  - LOAD_CELL: same as LOAD_LUT for cells. The accept at idx=NUM_CELLS-1 moves to CHECK.
  - CHECK: `cfg_ready`=1. An accepted word equal to the checksum moves to DONE; otherwise it moves to ERROR.
  - DONE: `cfg_done`=1, `cfg_ready`=0. `cfg_start` restarts at LOAD_LUT.
  - ERROR: `cfg_error`=1, `cfg_ready`=0. `cfg_start` restarts at LOAD_LUT.
- `cfg_start` is ignored in LOAD_LUT, LOAD_CELL and CHECK.
- On restart, `lut_mem` and `cell_cfg` keep their old contents until overwritten. `cfg_done` drops in the cycle after `cfg_start` is sampled.
- `cfg_data` is ignored when `cfg_valid`=0, and a held `cfg_valid` with `cfg_ready`=0 accepts nothing.

## Timing
- Reset, asynchronous:
  - State goes to IDLE; index and checksum go to 0.
  - `lut_mem`=0, `cell_cfg`=0.
  - `cfg_ready`=0, `cfg_done`=0, `cfg_error`=0, `fabric_en`=0.
- Reset mid-load discards the load entirely; a fresh `cfg_start` is required.
- `cfg_ready` is a registered function of state; it goes high one cycle after `cfg_start` is sampled in IDLE, DONE or ERROR.
- An accepted word is visible on `lut_mem`/`cell_cfg` after the same rising edge (one-cycle latency).
- `cfg_done`/`cfg_error` assert on the edge that accepts the checksum word.
- Full load takes NUM_LUTS+NUM_CELLS+1 accepts: 42 cycles minimum at defaults with `cfg_valid` held high.
- Gaps (`cfg_valid`=0) are allowed anywhere and stall progress without any other effect.

## Structure
- Package `fpga_cfg_pkg` holds:
  - state enum (IDLE, LOAD_LUT, LOAD_CELL, CHECK, DONE, ERROR);
  - `LUT_MEM_W`=33 and `CFG_WORD_W`=32;
  - default counts 24/17.
- One sub-module, `cfg_checksum_acc`: 32-bit accumulator with clear, add-enable and compare output.
- Index counter width is clog2 of max(NUM_LUTS, NUM_CELLS).

## Test plan
- Reset mid-stream: after 10 accepted words, pulse `reset`.
  - Required: all outputs 0 immediately.
  - Required: `cfg_ready`=0 until the next `cfg_start`.
- Nominal load at defaults:
  - Stimulus: 8×00000000, 8×FF00F0F0, 4×FAFAA0A0, 4×A5A55A5A; cell 0=00000000, cells 1..16=00000008; checksum 7A8773E8.
  - Required: `cfg_done`=1 and `fabric_en`=1 after word 42.
  - Required: LUT 8 reads 0FF00F0F0 (33-bit); cell 5 reads 00000008.
- Bad checksum: same stream with checksum 7A8773E9.
  - Required: `cfg_error`=1, `cfg_done`=0, `cfg_ready`=0; contents still loaded.
- Stalls: random `cfg_valid` gaps with the nominal stream.
  - Required: identical final outputs; no word is skipped or duplicated.
- Ignored and accepted starts:
  - `cfg_start` pulsed during LOAD_CELL: no effect, and the load completes.
  - `cfg_start` in DONE: `cfg_done` drops the next cycle.
  - A reload with LUT 0=12345678 then gives `lut_mem[32:0]`=012345678.
